// File: rtl/cpu_cpu_nios2_oci_dct_packer.sv
// -----------------------------------------------------------------------------
// cpu_cpu_nios2_oci_dct_packer
//
// Direct-compressed-trace packer. Two-bit trace codes from the CPU are shifted
// into a 30-bit accumulation buffer (15 codes, newest in [1:0]). A completed
// or flushed buffer is moved into a one-entry frame register that drains to
// the trace FIFO over a valid/ready handshake. When the frame register stays
// occupied and the buffer is full, further codes are dropped and counted.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   trc_on_i       trace enable; a falling edge requests a flush
//   dct_valid_i    a code is offered this cycle
//   dct_code_i     2-bit trace code
//   flush_i        single-cycle request to emit a partial buffer
//   dct_buffer_o   live accumulation buffer
//   dct_count_o    codes currently held in the buffer (0..15)
//   frame_valid_o  frame register holds a frame
//   frame_data_o   frame contents
//   frame_count_o  valid codes in frame_data_o (1..15)
//   frame_ready_i  consumer takes the frame when frame_valid_o is high
//   overflow_o     sticky: at least one code was dropped
//   drop_cnt_o     saturating count of dropped codes
// -----------------------------------------------------------------------------
module cpu_cpu_nios2_oci_dct_packer #(
   parameter int unsigned ENTRIES = 15,
   parameter int unsigned DROP_W  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  trc_on_i,
   input  logic                  dct_valid_i,
   input  logic [1:0]            dct_code_i,
   input  logic                  flush_i,
   output logic [2*ENTRIES-1:0]  dct_buffer_o,
   output logic [3:0]            dct_count_o,
   output logic                  frame_valid_o,
   output logic [2*ENTRIES-1:0]  frame_data_o,
   output logic [3:0]            frame_count_o,
   input  logic                  frame_ready_i,
   output logic                  overflow_o,
   output logic [DROP_W-1:0]     drop_cnt_o
);

   localparam int unsigned BufW    = 2 * ENTRIES;
   localparam logic [3:0]  FullCnt = 4'(ENTRIES);

   logic [BufW-1:0]   buf_q, buf_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic              trc_on_q;
   logic              frame_valid_q, frame_valid_d;
   logic [BufW-1:0]   frame_data_q, frame_data_d;
   logic [3:0]        frame_count_q, frame_count_d;
   logic              overflow_q, overflow_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic              acc;
   logic              frame_free;
   logic              flush_req;
   logic              want_flush;
   logic              load;
   logic [BufW-1:0]   ld_data;
   logic [3:0]        ld_cnt;
   logic [BufW-1:0]   shifted;
   logic [BufW-1:0]   nxt_buf;
   logic [3:0]        nxt_cnt;

   assign acc        = dct_valid_i & trc_on_i;
   // Free once any handshake in this cycle has been taken into account.
   assign frame_free = ~frame_valid_q | frame_ready_i;
   assign flush_req  = flush_i | (trc_on_q & ~trc_on_i);
   assign want_flush = pend_q | flush_req;
   assign shifted    = {buf_q[BufW-3:0], dct_code_i};

   always_comb begin
      buf_d      = buf_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      load       = 1'b0;
      ld_data    = '0;
      ld_cnt     = '0;
      nxt_buf    = buf_q;
      nxt_cnt    = cnt_q;

      if (cnt_q == FullCnt) begin
         if (frame_free) begin
            // FULL drain; a code arriving now starts the next buffer.
            load    = 1'b1;
            ld_data = buf_q;
            ld_cnt  = FullCnt;
            if (acc) begin
               buf_d = {{(BufW-2){1'b0}}, dct_code_i};
               cnt_d = 4'd1;
            end else begin
               buf_d = '0;
               cnt_d = 4'd0;
            end
            // The drained frame already serviced any older request; only a
            // request arriving with the new code stays pending for it.
            pend_d = acc & flush_req;
         end else begin
            pend_d = 1'b0;
            if (acc) begin
               overflow_d = 1'b1;
               if (drop_q != {DROP_W{1'b1}}) begin
                  drop_d = drop_q + DROP_W'(1);
               end
            end
         end
      end else begin
         // Append first, then decide whether the result must be emitted.
         nxt_buf = acc ? shifted : buf_q;
         nxt_cnt = cnt_q + {3'b000, acc};
         if ((nxt_cnt == FullCnt) || (want_flush && (nxt_cnt != 4'd0))) begin
            if (frame_free) begin
               load    = 1'b1;
               ld_data = nxt_buf;
               ld_cnt  = nxt_cnt;
               buf_d   = '0;
               cnt_d   = 4'd0;
               pend_d  = 1'b0;
            end else begin
               buf_d  = nxt_buf;
               cnt_d  = nxt_cnt;
               // A buffer that reaches FULL is drained unconditionally.
               pend_d = want_flush & (nxt_cnt != FullCnt);
            end
         end else begin
            buf_d  = nxt_buf;
            cnt_d  = nxt_cnt;
            pend_d = 1'b0;
         end
      end

      frame_valid_d = load | (frame_valid_q & ~frame_ready_i);
      frame_data_d  = load ? ld_data : frame_data_q;
      frame_count_d = load ? ld_cnt : frame_count_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_q         <= '0;
         cnt_q         <= '0;
         pend_q        <= 1'b0;
         trc_on_q      <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_data_q  <= '0;
         frame_count_q <= '0;
         overflow_q    <= 1'b0;
         drop_q        <= '0;
      end else begin
         buf_q         <= buf_d;
         cnt_q         <= cnt_d;
         pend_q        <= pend_d;
         trc_on_q      <= trc_on_i;
         frame_valid_q <= frame_valid_d;
         frame_data_q  <= frame_data_d;
         frame_count_q <= frame_count_d;
         overflow_q    <= overflow_d;
         drop_q        <= drop_d;
      end
   end

   assign dct_buffer_o  = buf_q;
   assign dct_count_o   = cnt_q;
   assign frame_valid_o = frame_valid_q;
   assign frame_data_o  = frame_data_q;
   assign frame_count_o = frame_count_q;
   assign overflow_o    = overflow_q;
   assign drop_cnt_o    = drop_q;

endmodule
